// File: rtl/hsv_color_tracker.sv
// HSV window classifier: emits a 1-cycle-latency mask stream and publishes the
// bounding box and count of matching pixels once per completed frame.
module hsv_color_tracker #(
    parameter int unsigned X_W        = 11,
    parameter int unsigned Y_W        = 10,
    parameter int unsigned CNT_W      = 20,
    parameter int unsigned MIN_PIXELS = 64
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             hsv_de,
    input  logic             hsv_vs,
    input  logic [23:0]      hsv24,
    input  logic [7:0]       h_lo,
    input  logic [7:0]       h_hi,
    input  logic [7:0]       s_lo,
    input  logic [7:0]       v_lo,
    output logic             mask_de,
    output logic             mask_vs,
    output logic             mask_bit,
    output logic             box_valid,
    output logic             box_found,
    output logic [X_W-1:0]   x_min,
    output logic [X_W-1:0]   x_max,
    output logic [Y_W-1:0]   y_min,
    output logic [Y_W-1:0]   y_max,
    output logic [CNT_W-1:0] pix_cnt
);
    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PIXELS);

    typedef enum logic [1:0] {S_WAIT, S_VSYNC, S_ACTIVE} state_t;

    state_t           state;
    logic             de_d1;
    logic             vs_d1;
    logic [X_W-1:0]   x_cnt;
    logic [Y_W-1:0]   y_cnt;
    logic [X_W-1:0]   acc_xmin;
    logic [X_W-1:0]   acc_xmax;
    logic [Y_W-1:0]   acc_ymin;
    logic [Y_W-1:0]   acc_ymax;
    logic [CNT_W-1:0] acc_cnt;

    logic [7:0] hue;
    logic [7:0] sat;
    logic [7:0] val;
    logic       hue_ok_c;
    logic       match_c;
    logic       vs_rise_c;
    logic       found_c;

    assign hue = hsv24[23:16];
    assign sat = hsv24[15:8];
    assign val = hsv24[7:0];

    // h_lo > h_hi selects a window that wraps through hue 0 (reds)
    assign hue_ok_c  = (h_lo <= h_hi) ? ((hue >= h_lo) && (hue <= h_hi))
                                      : ((hue >= h_lo) || (hue <= h_hi));
    assign match_c   = hsv_de & hue_ok_c & (sat >= s_lo) & (val >= v_lo);
    assign vs_rise_c = hsv_vs & ~vs_d1;
    assign found_c   = (acc_cnt >= MIN_CNT);

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state     <= S_WAIT;
            de_d1     <= 1'b0;
            vs_d1     <= 1'b0;
            x_cnt     <= '0;
            y_cnt     <= '0;
            acc_xmin  <= '1;
            acc_xmax  <= '0;
            acc_ymin  <= '1;
            acc_ymax  <= '0;
            acc_cnt   <= '0;
            mask_de   <= 1'b0;
            mask_vs   <= 1'b0;
            mask_bit  <= 1'b0;
            box_valid <= 1'b0;
            box_found <= 1'b0;
            x_min     <= '0;
            x_max     <= '0;
            y_min     <= '0;
            y_max     <= '0;
            pix_cnt   <= '0;
        end else begin
            de_d1     <= hsv_de;
            vs_d1     <= hsv_vs;
            mask_de   <= hsv_de;
            mask_vs   <= hsv_vs;
            mask_bit  <= match_c;
            box_valid <= 1'b0;

            // x/y hold the position of the pixel currently on hsv24
            if (hsv_de) begin
                if (x_cnt != '1) x_cnt <= x_cnt + X_W'(1);
            end else if (de_d1) begin
                x_cnt <= '0;
                if (y_cnt != '1) y_cnt <= y_cnt + Y_W'(1);
            end
            if (vs_rise_c) y_cnt <= '0;

            case (state)
                S_WAIT: begin
                    if (vs_rise_c) state <= S_VSYNC;
                end
                S_VSYNC: begin
                    acc_xmin <= '1;
                    acc_xmax <= '0;
                    acc_ymin <= '1;
                    acc_ymax <= '0;
                    acc_cnt  <= '0;
                    x_cnt    <= '0;
                    y_cnt    <= '0;
                    if (!hsv_vs) state <= S_ACTIVE;
                end
                S_ACTIVE: begin
                    // a pixel arriving with the closing vs edge is left out of the frame
                    if (vs_rise_c) begin
                        box_valid <= 1'b1;
                        box_found <= found_c;
                        pix_cnt   <= acc_cnt;
                        x_min     <= found_c ? acc_xmin : '0;
                        x_max     <= found_c ? acc_xmax : '0;
                        y_min     <= found_c ? acc_ymin : '0;
                        y_max     <= found_c ? acc_ymax : '0;
                        state     <= S_VSYNC;
                    end else if (match_c) begin
                        if (x_cnt < acc_xmin) acc_xmin <= x_cnt;
                        if (x_cnt > acc_xmax) acc_xmax <= x_cnt;
                        if (y_cnt < acc_ymin) acc_ymin <= y_cnt;
                        if (y_cnt > acc_ymax) acc_ymax <= y_cnt;
                        if (acc_cnt != '1) acc_cnt <= acc_cnt + CNT_W'(1);
                    end
                end
                default: state <= S_WAIT;
            endcase
        end
    end
endmodule

// File: tb/tb_hsv_color_tracker.sv
// Scoreboard bench for hsv_color_tracker: per-cycle mask expectations and
// per-frame box expectations are queued by the stimulus and popped by a monitor.
module tb_hsv_color_tracker;
    localparam int unsigned X_W        = 11;
    localparam int unsigned Y_W        = 10;
    localparam int unsigned CNT_W      = 20;
    localparam int unsigned MIN_PIXELS = 64;

    localparam logic [23:0] PX_HIT  = {8'd30, 8'd60, 8'd60};
    localparam logic [23:0] PX_MISS = {8'd100, 8'd0, 8'd0};

    logic             pclk = 1'b0;
    logic             rst;
    logic             hsv_de;
    logic             hsv_vs;
    logic [23:0]      hsv24;
    logic [7:0]       h_lo;
    logic [7:0]       h_hi;
    logic [7:0]       s_lo;
    logic [7:0]       v_lo;
    logic             mask_de;
    logic             mask_vs;
    logic             mask_bit;
    logic             box_valid;
    logic             box_found;
    logic [X_W-1:0]   x_min;
    logic [X_W-1:0]   x_max;
    logic [Y_W-1:0]   y_min;
    logic [Y_W-1:0]   y_max;
    logic [CNT_W-1:0] pix_cnt;

    hsv_color_tracker #(
        .X_W(X_W), .Y_W(Y_W), .CNT_W(CNT_W), .MIN_PIXELS(MIN_PIXELS)
    ) dut (
        .pclk(pclk), .rst(rst), .hsv_de(hsv_de), .hsv_vs(hsv_vs), .hsv24(hsv24),
        .h_lo(h_lo), .h_hi(h_hi), .s_lo(s_lo), .v_lo(v_lo),
        .mask_de(mask_de), .mask_vs(mask_vs), .mask_bit(mask_bit),
        .box_valid(box_valid), .box_found(box_found),
        .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
        .pix_cnt(pix_cnt)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        int found;
        int xmin;
        int xmax;
        int ymin;
        int ymax;
        int cnt;
    } box_t;

    logic [2:0] exp_q[$];   // {mask_de, mask_vs, mask_bit} per clocked input cycle
    box_t       box_q[$];
    box_t       last_box;
    int         n_chk = 0;
    int         n_err = 0;
    bit         mon_en = 1'b0;

    // frame model: plain statistics over the pixel coordinates the bench drives
    int vs_seen;
    int m_cnt, m_xmin, m_xmax, m_ymin, m_ymax;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit ref_match(input logic [23:0] px);
        int h = int'(px[23:16]);
        int s = int'(px[15:8]);
        int v = int'(px[7:0]);
        bit hue_ok;
        if (h_lo <= h_hi) hue_ok = (h >= int'(h_lo)) && (h <= int'(h_hi));
        else              hue_ok = (h >= int'(h_lo)) || (h <= int'(h_hi));
        return hue_ok && (s >= int'(s_lo)) && (v >= int'(v_lo));
    endfunction

    task automatic model_clear();
        m_cnt  = 0;
        m_xmin = 1 << 30;
        m_xmax = -1;
        m_ymin = 1 << 30;
        m_ymax = -1;
    endtask

    task automatic tick();
        exp_q.push_back({hsv_de, hsv_vs, hsv_de & ref_match(hsv24)});
        @(posedge pclk);
        #1;
        mon_en = 1'b1;
    endtask

    task automatic idle(input int n, input logic vs);
        hsv_de = 1'b0;
        hsv_vs = vs;
        repeat (n) begin
            hsv24 = 24'($urandom);
            tick();
        end
    endtask

    task automatic send_px(input logic [23:0] px, input int col, input int row);
        hsv_de = 1'b1;
        hsv_vs = 1'b0;
        hsv24  = px;
        if (ref_match(px)) begin
            m_cnt++;
            if (col < m_xmin) m_xmin = col;
            if (col > m_xmax) m_xmax = col;
            if (row < m_ymin) m_ymin = row;
            if (row > m_ymax) m_ymax = row;
        end
        tick();
    endtask

    // the frame that just ended is reported only if a full frame preceded it since reset
    task automatic vs_start(input bit de_px, input logic [23:0] px);
        box_t b;
        if (vs_seen > 0) begin
            b.found = (m_cnt >= int'(MIN_PIXELS)) ? 1 : 0;
            b.xmin  = b.found ? m_xmin : 0;
            b.xmax  = b.found ? m_xmax : 0;
            b.ymin  = b.found ? m_ymin : 0;
            b.ymax  = b.found ? m_ymax : 0;
            b.cnt   = m_cnt;
            box_q.push_back(b);
        end
        vs_seen++;
        model_clear();
        hsv_vs = 1'b1;
        hsv_de = de_px;
        hsv24  = px;
        tick();
        idle(2, 1'b1);
        idle(2, 1'b0);
    endtask

    task automatic rand_thresh();
        h_lo = 8'($urandom_range(0, 179));
        h_hi = 8'($urandom_range(0, 179));
        s_lo = 8'($urandom_range(0, 120));
        v_lo = 8'($urandom_range(0, 120));
    endtask

    task automatic set_thresh(input int hl, input int hh, input int sl, input int vl);
        h_lo = 8'(hl);
        h_hi = 8'(hh);
        s_lo = 8'(sl);
        v_lo = 8'(vl);
    endtask

    function automatic logic [23:0] gen_px(input int mode, input int c, input int r);
        case (mode)
            1: return (c >= 20 && c <= 29 && r >= 5 && r <= 12) ? PX_HIT : PX_MISS;
            2: return (r == 3 && c >= 10 && c <= 17) ? PX_HIT : PX_MISS;
            3: return ((r == 0 && c == 0) || (r == 47 && c == 63) || r == 20) ? PX_HIT : PX_MISS;
            default: return {8'($urandom_range(0, 179)), 8'($urandom_range(0, 255)),
                             8'($urandom_range(0, 255))};
        endcase
    endfunction

    task automatic frame_lines(input int w, input int r0, input int r1, input int mode);
        for (int r = r0; r <= r1; r++) begin
            for (int c = 0; c < w; c++) begin
                if (mode == 0 && r == (r0 + r1) / 2 && c == w / 2) rand_thresh();
                send_px(gen_px(mode, c, r), c, r);
            end
            idle((mode == 0) ? int'($urandom_range(1, 4)) : 4, 1'b0);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_mask_de"}, mask_de, 0);
        chk({tag, "_mask_vs"}, mask_vs, 0);
        chk({tag, "_mask_bit"}, mask_bit, 0);
        chk({tag, "_box_valid"}, box_valid, 0);
        chk({tag, "_box_found"}, box_found, 0);
        chk({tag, "_x_min"}, x_min, 0);
        chk({tag, "_x_max"}, x_max, 0);
        chk({tag, "_y_min"}, y_min, 0);
        chk({tag, "_y_max"}, y_max, 0);
        chk({tag, "_pix_cnt"}, pix_cnt, 0);
    endtask

    always @(negedge pclk) begin : monitor
        logic [2:0] e;
        box_t       b;
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                chk("mask_queue_empty", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("mask_de", mask_de, e[2]);
                chk("mask_vs", mask_vs, e[1]);
                chk("mask_bit", mask_bit, e[0]);
            end
            if (box_valid) begin
                if (box_q.size() == 0) begin
                    chk("unexpected_box_valid", box_valid, 0);
                end else begin
                    b = box_q.pop_front();
                    last_box = b;
                    chk("box_found", box_found, b.found);
                    chk("x_min", x_min, b.xmin);
                    chk("x_max", x_max, b.xmax);
                    chk("y_min", y_min, b.ymin);
                    chk("y_max", y_max, b.ymax);
                    chk("pix_cnt", pix_cnt, b.cnt);
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation still running, expected to finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst    = 1'b1;
        hsv_de = 1'b0;
        hsv_vs = 1'b0;
        hsv24  = '0;
        set_thresh(20, 40, 50, 50);
        vs_seen = 0;
        model_clear();
        repeat (2) @(posedge pclk);
        #1;
        check_zero("rst0");
        rst = 1'b0;
        idle(3, 1'b0);

        // 64x48 frame with a 10x8 matching block; reported at the next vs edge
        vs_start(1'b0, '0);
        frame_lines(64, 0, 47, 1);

        // next frame gets a mid-line reset after the box outputs hold real values
        vs_start(1'b0, '0);
        frame_lines(64, 0, 2, 0);
        for (int c = 0; c < 5; c++) send_px(gen_px(0, c, 3), c, 3);
        rst    = 1'b1;
        mon_en = 1'b0;
        exp_q.delete();
        hsv_de = 1'b0;
        #2;
        check_zero("rst_mid");
        @(posedge pclk);
        @(posedge pclk);
        #1;
        rst     = 1'b0;
        vs_seen = 0;
        model_clear();
        frame_lines(64, 4, 47, 0);

        // first full frame after reset: below minimum, pulse only at its closing edge
        set_thresh(20, 40, 50, 50);
        vs_start(1'b0, '0);
        frame_lines(64, 0, 47, 2);

        // plain window classification
        vs_start(1'b0, '0);
        send_px({8'd30, 8'd60, 8'd60}, 0, 0);
        send_px({8'd41, 8'd60, 8'd60}, 1, 0);
        send_px({8'd30, 8'd49, 8'd200}, 2, 0);
        idle(4, 1'b0);

        // wrapped hue window
        set_thresh(170, 10, 0, 0);
        vs_start(1'b0, '0);
        send_px({8'd175, 8'd128, 8'd128}, 0, 0);
        send_px({8'd5, 8'd128, 8'd128}, 1, 0);
        send_px({8'd90, 8'd128, 8'd128}, 2, 0);
        send_px({8'd170, 8'd128, 8'd128}, 3, 0);
        send_px({8'd10, 8'd128, 8'd128}, 4, 0);
        idle(4, 1'b0);

        // corner matches; the closing vs edge carries a matching pixel
        set_thresh(20, 40, 50, 50);
        vs_start(1'b0, '0);
        frame_lines(64, 0, 47, 3);
        vs_start(1'b1, PX_HIT);

        // random frames with thresholds changing mid-frame
        for (int k = 0; k < 4; k++) begin
            rand_thresh();
            frame_lines(16, 0, 11, 0);
            vs_start(1'b0, '0);
        end
        idle(6, 1'b0);
        @(negedge pclk);
        #1;
        chk("box_queue_drained", box_q.size(), 0);
        chk("mask_queue_drained", exp_q.size(), 0);
        chk("hold_box_found", box_found, last_box.found);
        chk("hold_x_min", x_min, last_box.xmin);
        chk("hold_x_max", x_max, last_box.xmax);
        chk("hold_y_min", y_min, last_box.ymin);
        chk("hold_y_max", y_max, last_box.ymax);
        chk("hold_pix_cnt", pix_cnt, last_box.cnt);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
